// File: rtl/avmm_mult_master.sv
// Avalon-MM master: reads operands A/B from the operand RAM, multiplies, writes the 64-bit product back.
// Define AVMM_MULT_SIGNED_EN for a two's-complement product (unsigned otherwise).
module avmm_mult_master #(
  parameter int ADDR_W  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_A  = 0,
  parameter int ADDR_B  = 1,
  parameter int ADDR_LO = 2,
  parameter int ADDR_HI = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [2*DATA_W-1:0] result,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [3:0]          avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_waitrequest,
  input  logic                avm_readdatavalid
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {IDLE, RD_A, WT_A, RD_B, WT_B, MUL_ST, WR_LO, WR_HI, FIN} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d, rd_q, rd_d, wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, a_q, a_d, b_q, b_d;
  logic [3:0]          be_q, be_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] a_ext, b_ext, prod;
  logic                rd_acc, wr_acc;

`ifdef AVMM_MULT_SIGNED_EN
  assign a_ext = {{DATA_W{a_q[DATA_W-1]}}, a_q};
  assign b_ext = {{DATA_W{b_q[DATA_W-1]}}, b_q};
`else
  assign a_ext = {{DATA_W{1'b0}}, a_q};
  assign b_ext = {{DATA_W{1'b0}}, b_q};
`endif
  // Low 2*DATA_W bits of the widened product equal the exact product in either signedness.
  assign prod   = a_ext * b_ext;
  assign rd_acc = rd_q & ~avm_waitrequest;
  assign wr_acc = wr_q & ~avm_waitrequest;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    result_d = result_q;
    addr_d   = addr_q;
    cs_d     = cs_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RD_A;
        busy_d  = 1'b1;
        error_d = 1'b0;
        rd_d    = 1'b1;
        cs_d    = 1'b1;
        addr_d  = ADDR_W'(ADDR_A);
      end
      RD_A, RD_B: if (rd_acc) begin
        rd_d    = 1'b0;
        cs_d    = 1'b0;
        cnt_d   = '0;
        state_d = (state_q == RD_A) ? WT_A : WT_B;
      end
      WT_A, WT_B: begin
        if (avm_readdatavalid) begin
          if (state_q == WT_A) begin
            a_d     = avm_readdata;
            state_d = RD_B;
            rd_d    = 1'b1;
            cs_d    = 1'b1;
            addr_d  = ADDR_W'(ADDR_B);
          end else begin
            b_d     = avm_readdata;
            state_d = MUL_ST;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MUL_ST: begin
        result_d = prod;
        state_d  = WR_LO;
        wr_d     = 1'b1;
        cs_d     = 1'b1;
        be_d     = 4'hF;
        addr_d   = ADDR_W'(ADDR_LO);
        wdata_d  = prod[DATA_W-1:0];
      end
      WR_LO: if (wr_acc) begin
        state_d = WR_HI;
        addr_d  = ADDR_W'(ADDR_HI);
        wdata_d = result_q[2*DATA_W-1:DATA_W];
      end
      WR_HI: if (wr_acc) begin
        state_d = FIN;
        wr_d    = 1'b0;
        cs_d    = 1'b0;
        be_d    = 4'h0;
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      addr_q   <= '0;
      cs_q     <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      be_q     <= 4'h0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign result         = result_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
endmodule
